skin_bbox: RTL

- Sits directly downstream of the RGB-to-YCbCr converter in the neuro_skin pipeline.
- Classifies each active pixel as skin or non-skin using fixed Y/Cb/Cr window thresholds.
- Emits a 1-bit skin mask stream with re-aligned syncs.
- Accumulates per-frame statistics (bounding box, skin pixel count) and publishes them once per frame on the vsync rising edge.

---
 rtl/skin_bbox_pkg.sv | 17 +
 rtl/skin_bbox_if.sv | 22 ++
 rtl/skin_classify.sv | 47 ++++
 rtl/skin_bbox.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/skin_bbox_pkg.sv
// Shared constants for the skin_bbox block: default YCbCr skin
// window, counter widths and the two-state FSM encoding.
package skin_bbox_pkg;

  localparam logic [7:0] Y_MIN  = 8'd16;
  localparam logic [7:0] CB_MIN = 8'd77;
  localparam logic [7:0] CB_MAX = 8'd127;
  localparam logic [7:0] CR_MIN = 8'd133;
  localparam logic [7:0] CR_MAX = 8'd173;

  localparam int CW = 11;
  localparam int NW = 21;

  localparam logic [0:0] WAIT_VSYNC = 1'b0;
  localparam logic [0:0] ACTIVE     = 1'b1;

endpackage

// File: rtl/skin_bbox_if.sv
// YCbCr pixel stream with syncs entering skin_bbox.
// master drives de/hsync/vsync and Y/Cb/Cr, slave samples them.
interface skin_bbox_if;

  logic       de_in;
  logic       hsync_in;
  logic       vsync_in;
  logic [7:0] Y;
  logic [7:0] Cb;
  logic [7:0] Cr;

  modport master (
    output de_in, hsync_in, vsync_in,
    output Y, Cb, Cr
  );

  modport slave (
    input de_in, hsync_in, vsync_in,
    input Y, Cb, Cr
  );

endinterface

// File: rtl/skin_classify.sv
// Skin window compare (skin: combinational) plus a one-ce-cycle
// register stage for mask_out and the de/hsync/vsync syncs.
module skin_classify
  import skin_bbox_pkg::*;
#(
  parameter logic [7:0] P_Y_MIN  = Y_MIN,
  parameter logic [7:0] P_CB_MIN = CB_MIN,
  parameter logic [7:0] P_CB_MAX = CB_MAX,
  parameter logic [7:0] P_CR_MIN = CR_MIN,
  parameter logic [7:0] P_CR_MAX = CR_MAX
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  input  logic       de,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [7:0] y,
  input  logic [7:0] cb,
  input  logic [7:0] cr,
  output logic       skin,
  output logic       mask_out,
  output logic       de_out,
  output logic       hsync_out,
  output logic       vsync_out
);

  assign skin = de
    & (y >= P_Y_MIN)
    & (cb >= P_CB_MIN) & (cb <= P_CB_MAX)
    & (cr >= P_CR_MIN) & (cr <= P_CR_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_out  <= 1'b0;
      de_out    <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else if (ce) begin
      mask_out  <= skin;
      de_out    <= de;
      hsync_out <= hsync;
      vsync_out <= vsync;
    end
  end

endmodule

// File: rtl/skin_bbox.sv
// Skin mask stream plus per-frame bounding box / pixel count,
// published on each vsync rising edge with a frame_valid pulse.
module skin_bbox
  import skin_bbox_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  skin_bbox_if.slave    pix,
  output logic          mask_out,
  output logic          de_out,
  output logic          hsync_out,
  output logic          vsync_out,
  output logic          frame_valid,
  output logic          skin_found,
  output logic [CW-1:0] x_min,
  output logic [CW-1:0] x_max,
  output logic [CW-1:0] y_min,
  output logic [CW-1:0] y_max,
  output logic [NW-1:0] skin_count
);

  logic          skin;
  logic          vs_rise;
  logic          de_fall;
  logic          acc_go;
  logic          publish;
  logic [0:0]    state;
  logic [CW-1:0] x_cnt, y_cnt;
  logic [CW-1:0] cx, cy, nx, ny;
  logic [CW-1:0] a_xmin, a_xmax;
  logic [CW-1:0] a_ymin, a_ymax;
  logic [NW-1:0] a_cnt;
  logic          a_found;
  logic [CW-1:0] n_xmin, n_xmax;
  logic [CW-1:0] n_ymin, n_ymax;
  logic [NW-1:0] n_cnt;
  logic          n_found;

  // The registered syncs double as the edge-detect history.
  skin_classify u_cls (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .de        (pix.de_in),
    .hsync     (pix.hsync_in),
    .vsync     (pix.vsync_in),
    .y         (pix.Y),
    .cb        (pix.Cb),
    .cr        (pix.Cr),
    .skin      (skin),
    .mask_out  (mask_out),
    .de_out    (de_out),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out)
  );

  assign vs_rise = ~vsync_out & pix.vsync_in;
  assign de_fall = de_out & ~pix.de_in;
  assign acc_go  = (state == ACTIVE) | vs_rise;
  assign publish = (state == ACTIVE) & vs_rise;

  // A pixel on the vsync edge sits at (0,0) of the new frame.
  always_comb begin
    cx = vs_rise ? '0 : x_cnt;
    cy = vs_rise ? '0 : y_cnt;
    nx = cx;
    ny = cy;
    if (pix.de_in) begin
      if (cx != '1) nx = cx + CW'(1);
    end else if (de_fall) begin
      nx = '0;
      if (!vs_rise && cy != '1) ny = cy + CW'(1);
    end
  end

  always_comb begin
    n_xmin  = vs_rise ? '1 : a_xmin;
    n_xmax  = vs_rise ? '0 : a_xmax;
    n_ymin  = vs_rise ? '1 : a_ymin;
    n_ymax  = vs_rise ? '0 : a_ymax;
    n_cnt   = vs_rise ? '0 : a_cnt;
    n_found = vs_rise ? 1'b0 : a_found;
    if (acc_go && skin) begin
      if (cx < n_xmin) n_xmin = cx;
      if (cx > n_xmax) n_xmax = cx;
      if (cy < n_ymin) n_ymin = cy;
      if (cy > n_ymax) n_ymax = cy;
      if (n_cnt != '1) n_cnt = n_cnt + NW'(1);
      n_found = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= WAIT_VSYNC;
      x_cnt   <= '0;
      y_cnt   <= '0;
      a_xmin  <= '0;
      a_xmax  <= '0;
      a_ymin  <= '0;
      a_ymax  <= '0;
      a_cnt   <= '0;
      a_found <= 1'b0;
    end else if (ce) begin
      if (vs_rise) state <= ACTIVE;
      x_cnt   <= nx;
      y_cnt   <= ny;
      a_xmin  <= n_xmin;
      a_xmax  <= n_xmax;
      a_ymin  <= n_ymin;
      a_ymax  <= n_ymax;
      a_cnt   <= n_cnt;
      a_found <= n_found;
    end
  end

  // Empty frames publish zeros, not the all-ones clear value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_valid <= 1'b0;
      skin_found  <= 1'b0;
      x_min       <= '0;
      x_max       <= '0;
      y_min       <= '0;
      y_max       <= '0;
      skin_count  <= '0;
    end else if (ce) begin
      frame_valid <= publish;
      if (publish) begin
        skin_found <= a_found;
        skin_count <= a_cnt;
        x_min      <= a_found ? a_xmin : '0;
        x_max      <= a_found ? a_xmax : '0;
        y_min      <= a_found ? a_ymin : '0;
        y_max      <= a_found ? a_ymax : '0;
      end
    end
  end

endmodule
